ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, RAM word-address width (64 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_req, b_req  input  1 each  access request from port A (CPU data) or port B (debug/board); held high until the port's gnt is seen.
REQ-006 a_we, b_we  input  1 each  1 = write, 0 = read; stable while req is high.
REQ-007 a_addr, b_addr  input  ADDR_W each  word address; stable while req is high.
REQ-008 a_wdata, b_wdata  input  DATA_W each  write data; stable while req is high.
REQ-009 a_gnt, b_gnt  output  1 each  one-cycle pulse: request accepted and latched.
REQ-010 a_done, b_done  output  1 each  one-cycle pulse: access complete (read data valid on a read).
REQ-011 a_rdata, b_rdata  output  DATA_W each  registered read data; holds until that port's next read completes.
REQ-012 ram_we  output  1  write enable to the single-port RAM.
REQ-013 ram_addr  output  ADDR_W  RAM address, registered.
REQ-014 ram_din  output  DATA_W  RAM write data, registered.
REQ-015 ram_dout  input  DATA_W  RAM read data, valid one cycle after the address edge.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS, RDATA.
REQ-018 IDLE: if any req is high at an edge -> latch the winner's we/addr/wdata into ram_we/ram_addr/ram_din; pulse the winner's gnt; go to ACCESS.
REQ-019 ACCESS: RAM samples at the next edge. Write -> ram_we low, winner's done pulses next cycle, go to IDLE. Read -> go to RDATA.
REQ-020 RDATA: at the next edge, capture ram_dout into the winner's rdata, pulse the winner's done, go to IDLE.
REQ-021 Latency from the req-sampling edge: gnt at +1 cycle; write done at +2; read done and rdata at +3.
REQ-022 Requests SHALL be accepted only in IDLE; req high during ACCESS or RDATA waits.
REQ-023 Back-to-back: done and the next acceptance may occur on the same edge.
REQ-024 Simultaneous a_req and b_req SHALL be resolved per REQ-031/REQ-032; the loser stays pending with no gnt.
REQ-025 A req dropped before it is sampled in IDLE SHALL be ignored with no gnt or done.
REQ-026 ram_we SHALL be high only during an ACCESS cycle for a write; ram_addr and ram_din hold their last value otherwise.
REQ-027 The non-owning port's gnt, done and rdata SHALL be unaffected by an access.

Reset
REQ-028 Rst_n low SHALL immediately force: state IDLE, all gnt/done low, ram_we low, busy low, ram_addr/ram_din/a_rdata/b_rdata zero, priority pointer to A.
REQ-029 Reset mid-operation SHALL abort the access: no done, and no write if asserted before the ACCESS-cycle edge.
REQ-030 After Rst_n rises, the first edge with a req SHALL be treated as IDLE acceptance.

Configuration
REQ-031 With RAM_ARB_RR_EN defined: round-robin; after each grant, priority passes to the other port, so alternating service is guaranteed under continuous contention.
REQ-032 Without RAM_ARB_RR_EN: fixed priority, A always wins a tie; no priority pointer is synthesised.

Structure
REQ-033 Package ram_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RDATA), port-id type (PORT_A/PORT_B) and default width constants.
REQ-034 Sub-module ram_arb_pick SHALL hold the winner-selection logic (combinational pick plus the priority pointer under RAM_ARB_RR_EN).

Verification
REQ-035 Single read: preload addr 5 = 0xDEADBEEF; a_req read addr 5 -> a_gnt at +1, a_done at +3, a_rdata = 0xDEADBEEF, b_* quiet.
REQ-036 Write then read: b write addr 63 = 0x12345678, then b read addr 63 -> ram_we high for exactly one cycle, b_rdata = 0x12345678 at +3 after the read.
REQ-037 Contention: a_req and b_req held for 4 accesses -> RR_EN: order A,B,A,B; without: A,A,A,A with B starved.
REQ-038 Reset mid-write: Rst_n low during IDLE->ACCESS of a write to addr 7 (old 0x0) -> addr 7 reads 0x0 after reset, no done, all outputs zero.
REQ-039 Short req: a_req high for 0 sampled edges (glitch between edges) -> no gnt, no RAM access, busy stays low.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state/port types and default widths for the RAM arbiter.
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: chooses the winning port; the round-robin pointer exists only under RAM_ARB_RR_EN,
// otherwise port A always wins a tie.
module ram_arb_pick
  import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
  input  logic  clk,
  input  logic  rst_n,
  input  logic  take_i,
`endif
  input  logic  a_req_i,
  input  logic  b_req_i,
  output port_t win_o,
  output logic  any_o
);
  assign any_o = a_req_i | b_req_i;
`ifdef RAM_ARB_RR_EN
  port_t prio_q;
  assign win_o = (a_req_i && b_req_i) ? prio_q : (a_req_i ? PORT_A : PORT_B);
  // priority passes to the port that did not just win
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio_q <= PORT_A;
    else if (take_i) prio_q <= (win_o == PORT_A) ? PORT_B : PORT_A;
`else
  assign win_o = a_req_i ? PORT_A : PORT_B;
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; the default is fixed priority to port A.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              a_gnt_o,
  output logic              a_done_o,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              b_gnt_o,
  output logic              b_done_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              busy_o
);
  state_t            state_q;
  port_t             owner_q, win;
  logic              any, a_gnt_q, b_gnt_q, a_done_q, b_done_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q, a_rdata_q, b_rdata_q;
`ifdef RAM_ARB_RR_EN
  logic take;
  assign take = (state_q == IDLE) && any;
`endif
  ram_arb_pick u_pick (
`ifdef RAM_ARB_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .take_i (take),
`endif
    .a_req_i(a_req_i),
    .b_req_i(b_req_i),
    .win_o  (win),
    .any_o  (any)
  );
  // ram_we_q doubles as the read/write flag of the access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= PORT_A;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      case (state_q)
        IDLE: if (any) begin
          owner_q    <= win;
          ram_we_q   <= (win == PORT_A) ? a_we_i : b_we_i;
          ram_addr_q <= (win == PORT_A) ? a_addr_i : b_addr_i;
          ram_din_q  <= (win == PORT_A) ? a_wdata_i : b_wdata_i;
          a_gnt_q    <= (win == PORT_A);
          b_gnt_q    <= (win == PORT_B);
          state_q    <= ACCESS;
        end
        ACCESS: begin
          ram_we_q <= 1'b0;
          a_done_q <= ram_we_q && (owner_q == PORT_A);
          b_done_q <= ram_we_q && (owner_q == PORT_B);
          state_q  <= ram_we_q ? IDLE : RDATA;
        end
        RDATA: begin
          if (owner_q == PORT_A) a_rdata_q <= ram_dout_i;
          else b_rdata_q <= ram_dout_i;
          a_done_q <= (owner_q == PORT_A);
          b_done_q <= (owner_q == PORT_B);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign a_gnt_o    = a_gnt_q;
  assign b_gnt_o    = b_gnt_q;
  assign a_done_o   = a_done_q;
  assign b_done_o   = b_done_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench for ram_arbiter with a behavioural RAM and arbitration model.
module tb_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req, we, gnt, done;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd [2];
  logic [DW-1:0] rd [2];
  logic          ram_we, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] rexp [2];
  exp_t          sb [2][$];
  exp_t          e;
  int            order [$];
  int            checks = 0, errors = 0;
  int            cyc = 0, busy_cnt = 0, we_cycles = 0, win;
  bit            prev_idle = 1'b1, last_b = 1'b1, due;
  logic [1:0]    eg;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_i(req[0]), .a_we_i(we[0]), .a_addr_i(addr[0]), .a_wdata_i(wd[0]),
    .b_req_i(req[1]), .b_we_i(we[1]), .b_addr_i(addr[1]), .b_wdata_i(wd[1]),
    .a_gnt_o(gnt[0]), .a_done_o(done[0]), .a_rdata_o(rd[0]),
    .b_gnt_o(gnt[1]), .b_done_o(done[1]), .b_rdata_o(rd[1]),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din),
    .ram_dout_i(ram_dout), .busy_o(busy)
  );

  // synchronous single-port RAM: read data one cycle after the address edge
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rst_outputs();
    chk("rst_ctl", {58'd0, gnt, done, ram_we, busy}, 64'd0);
    chk("rst_ram", {26'd0, ram_addr, ram_din}, 64'd0);
    chk("rst_rdata", {rd[0], rd[1]}, 64'd0);
  endtask

  // monitor + reference model: grant decision, latencies, RAM strobes and read data
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_rst_outputs();
      sb[0].delete();
      sb[1].delete();
      rexp[0] = '0;
      rexp[1] = '0;
      busy_cnt = 0;
      prev_idle = 1'b1;
      last_b = 1'b1;
    end else begin
      eg = 2'b00;
      if (prev_idle && req != 2'b00) begin
        win = (req == 2'b11) ? ((RR && !last_b) ? 1 : 0) : (req[0] ? 0 : 1);
        eg[win] = 1'b1;
        last_b = (win == 1);
        order.push_back(win);
        chk("ram_we_at_gnt", ram_we, we[win]);
        chk("ram_addr_at_gnt", ram_addr, addr[win]);
        if (we[win]) chk("ram_din_at_gnt", ram_din, wd[win]);
        sb[win].push_back('{we[win], addr[win], wd[win], cyc + (we[win] ? 1 : 2)});
        busy_cnt = we[win] ? 1 : 2;
      end else chk("ram_we_idle", ram_we, 0);
      chk("gnt", gnt, eg);
      chk("busy", busy, busy_cnt > 0);
      prev_idle = (busy_cnt == 0);
      if (busy_cnt > 0) busy_cnt--;
      if (ram_we) we_cycles++;
      for (int p = 0; p < 2; p++) begin
        due = sb[p].size() > 0 && sb[p][0].due == cyc;
        chk(p ? "b_done" : "a_done", done[p], due);
        if (due) begin
          e = sb[p].pop_front();
          if (e.we) ref_mem[e.addr] = e.data;
          else rexp[p] = ref_mem[e.addr];
        end
        chk(p ? "b_rdata" : "a_rdata", rd[p], rexp[p]);
      end
    end
    cyc++;
  end

  // hold req until gnt is seen; returns the number of cycles waited
  task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int waits);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wd[p] = d; waits = 0;
    do begin @(negedge clk); #1; waits++; end while (!gnt[p] && waits < 1000);
    if (!gnt[p]) chk(p ? "b_gnt_timeout" : "a_gnt_timeout", gnt[p], 1);
    req[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      issue(p, 1'($urandom_range(1)), AW'($urandom_range(7)), $urandom, w);
      repeat ($urandom_range(3)) begin @(negedge clk); #1; end
    end
  endtask

  initial begin
    int w, we0;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
    rexp[0] = '0; rexp[1] = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    // request pulse that never sees an edge
    @(negedge clk); #1 req[0] = 1'b1; #2 req[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("glitch_busy", busy, 0);
      chk("glitch_gnt", gnt, 0);
    end
    #1;
    // single read of preloaded word
    issue(0, 1'b0, 6'd5, '0, w);
    chk("a_read_gnt_latency", w, 1);
    repeat (2) @(negedge clk);
    chk("a_read_done", done[0], 1);
    chk("a_rdata_5", rd[0], 32'hDEADBEEF);
    #1;
    // write then read on port B
    we0 = we_cycles;
    issue(1, 1'b1, 6'd63, 32'h12345678, w);
    chk("b_write_gnt_latency", w, 1);
    repeat (2) @(negedge clk);
    #1;
    issue(1, 1'b0, 6'd63, '0, w);
    repeat (2) @(negedge clk);
    chk("b_rdata_63", rd[1], 32'h12345678);
    chk("ram_we_pulses", we_cycles - we0, 1);
    #1;
    // reset in the middle of a write
    issue(1, 1'b1, 6'd7, 32'hCAFEF00D, w);
    rst_n = 1'b0;
    #1 chk_rst_outputs();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    issue(0, 1'b0, 6'd7, '0, w);
    chk("post_reset_gnt_latency", w, 1);
    repeat (2) @(negedge clk);
    chk("addr7_unwritten", rd[0], 0);
    chk("ram_addr7_unwritten", mem[7], 0);
    #1;
    // contention from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    order.delete();
    fork
      begin int wa; for (int i = 0; i < 4; i++) issue(0, 1'b0, AW'(i), '0, wa); end
      begin int wb; for (int i = 0; i < 4; i++) issue(1, 1'b0, AW'(i + 8), '0, wb); end
    join
    for (int i = 0; i < 4; i++) chk("contention_order", order[i], RR ? (i % 2) : 0);
    repeat (3) begin @(negedge clk); #1; end
    // randomized traffic on both ports
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb[0].size() + sb[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
